// File: rtl/cp0_pkg.sv
// Shared CP0 header: register numbers, exception codes and the handler entry address.
package cp0_pkg;

    localparam logic [4:0]  CP0_SR    = 5'd12;
    localparam logic [4:0]  CP0_CAUSE = 5'd13;
    localparam logic [4:0]  CP0_EPC   = 5'd14;
    localparam logic [4:0]  CP0_PRID  = 5'd15;

    localparam logic [4:0]  EXC_INT   = 5'd0;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;
    localparam logic [4:0]  EXC_ADES  = 5'd5;
    localparam logic [4:0]  EXC_RI    = 5'd10;
    localparam logic [4:0]  EXC_OV    = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, interrupt/exception detection and trap entry.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h4C57_2018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [6:2]  ExcCode,
    input  logic [7:2]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    logic [5:0]  im_q,  im_d;
    logic        exl_q, exl_d;
    logic        ie_q,  ie_d;
    logic        bd_q,  bd_d;
    logic [5:0]  ip_q,  ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [29:0] epc_q, epc_d;

    logic        int_pend_s;
    logic        exc_pend_s;
    logic        int_req_s;
    logic [31:0] trap_pc_s;
    logic [31:0] sr_s;
    logic [31:0] cause_s;
    logic        unused_s;

    assign int_pend_s = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_pend_s = (ExcCode != 5'd0) & ~exl_q;
    assign int_req_s  = int_pend_s | exc_pend_s;
    assign trap_pc_s  = BD ? (PC - 32'd4) : PC;

    assign sr_s    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_s = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};

    assign IntReq = int_req_s;
    assign EPC    = {epc_q, 2'b00};

    // Low address bits and unimplemented SR bits carry no state.
    assign unused_s = ^{PC[1:0], trap_pc_s[1:0], DIn[31:16], DIn[9:2]};

    // Combinational register read port.
    always_comb begin
        case (A1)
            CP0_SR:    DOut = sr_s;
            CP0_CAUSE: DOut = cause_s;
            CP0_EPC:   DOut = {epc_q, 2'b00};
            CP0_PRID:  DOut = PRID_VALUE;
            default:   DOut = 32'd0;
        endcase
    end

    // Next-state: trap entry has priority and suppresses the M-stage mtc0 and eret.
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = HWInt;
        if (int_req_s) begin
            exl_d = 1'b1;
            bd_d  = BD;
            epc_d = trap_pc_s[31:2];
            exc_d = int_pend_s ? EXC_INT : ExcCode;
        end else begin
            if (EXLClr) begin
                exl_d = 1'b0;
            end else begin
                exl_d = exl_q;
            end
            if (WE) begin
                case (A2)
                    CP0_SR: begin
                        im_d  = DIn[15:10];
                        exl_d = DIn[1];
                        ie_d  = DIn[0];
                    end
                    CP0_EPC: epc_d = DIn[31:2];
                    default: ;
                endcase
            end else begin
                epc_d = epc_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= 6'd0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= 6'd0;
            exc_q <= 5'd0;
            epc_q <= 30'd0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0 using immediate assertions.
module tb_cp0;

    localparam logic [31:0] PRID = 32'h4C57_2018;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] DIn, PC;
    logic        WE, BD, EXLClr;
    logic [6:2]  ExcCode;
    logic [7:2]  HWInt;
    logic        IntReq;
    logic [31:0] EPC, DOut;

    int checks = 0;
    int errors = 0;

    cp0 #(.PRID_VALUE(PRID)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .PC(PC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
        .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        A1 = a;
        #1;
        chk(tag, DOut, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0;
        PC = 32'd0; BD = 1'b0; ExcCode = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;

        // Reset state and read decode
        chk("rst_intreq", {31'd0, IntReq}, 32'd0);
        chk("rst_epc_port", EPC, 32'd0);
        rd(5'd12, "rst_sr", 32'd0);
        rd(5'd13, "rst_cause", 32'd0);
        rd(5'd14, "rst_epc", 32'd0);
        rd(5'd15, "prid", PRID);
        rd(5'd0,  "rd_reg0", 32'd0);
        rd(5'd16, "rd_reg16", 32'd0);

        // Enable IM2 and IE, then raise timer interrupt
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        WE = 1'b0;
        rd(5'd12, "sr_write", 32'h0000_0401);
        chk("no_int_yet", {31'd0, IntReq}, 32'd0);
        HWInt = 6'b000001; PC = 32'h0000_3000; BD = 1'b0;
        #1;
        chk("int_intreq", {31'd0, IntReq}, 32'd1);
        tick();
        rd(5'd13, "int_cause", 32'h0000_0400);
        rd(5'd12, "int_sr_exl", 32'h0000_0403);
        chk("int_epc", EPC, 32'h0000_3000);
        chk("int_masked_by_exl", {31'd0, IntReq}, 32'd0);

        // EXL blocks exceptions; IP still tracks HWInt
        ExcCode = 5'd12; HWInt = 6'b110000;
        #1;
        chk("exl_blocks", {31'd0, IntReq}, 32'd0);
        tick();
        rd(5'd13, "ip_update", 32'h0000_C000);
        chk("exl_epc_hold", EPC, 32'h0000_3000);
        ExcCode = 5'd0; HWInt = 6'd0; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd(5'd12, "exlclr", 32'h0000_0401);

        // AdEL in a delay slot
        ExcCode = 5'd4; PC = 32'h0000_3010; BD = 1'b1;
        #1;
        chk("adel_intreq", {31'd0, IntReq}, 32'd1);
        tick();
        ExcCode = 5'd0; BD = 1'b0;
        chk("adel_epc", EPC, 32'h0000_300C);
        rd(5'd13, "adel_cause", 32'h8000_0010);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;

        // Interrupt has priority over simultaneous AdES
        ExcCode = 5'd5; HWInt = 6'b000001; PC = 32'h0000_3020;
        #1;
        chk("prio_intreq", {31'd0, IntReq}, 32'd1);
        tick();
        ExcCode = 5'd0; HWInt = 6'd0;
        rd(5'd13, "prio_cause", 32'h0000_0400);
        chk("prio_epc", EPC, 32'h0000_3020);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;

        // mtc0 EPC discarded when trapping, committed otherwise
        WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3007; ExcCode = 5'd10; PC = 32'h0000_3040;
        tick();
        WE = 1'b0; ExcCode = 5'd0;
        chk("we_discard", EPC, 32'h0000_3040);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        WE = 1'b1;
        tick();
        WE = 1'b0;
        rd(5'd14, "epc_write", 32'h0000_3004);

        // EXLClr ignored when a trap is taken
        ExcCode = 5'd12; EXLClr = 1'b1; PC = 32'h0000_3050;
        tick();
        EXLClr = 1'b0;
        rd(5'd12, "exlclr_ignored", 32'h0000_0403);

        // Cause, PRId and out-of-range writes have no effect
        WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        rd(5'd13, "cause_ro", 32'h0000_0030);
        A2 = 5'd15;
        tick();
        rd(5'd15, "prid_ro", PRID);
        A2 = 5'd11;
        tick();
        rd(5'd12, "a2_11_nop", 32'h0000_0403);
        A2 = 5'd12;
        tick();
        rd(5'd12, "sr_mask", 32'h0000_FC03);

        // Reset overrides a pending write
        ExcCode = 5'd0; DIn = 32'h0000_FC01; reset = 1'b1;
        tick();
        reset = 1'b0; WE = 1'b0;
        rd(5'd12, "rst_ovr_sr", 32'd0);
        rd(5'd13, "rst_ovr_cause", 32'd0);
        chk("rst_ovr_epc", EPC, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
